// File: rtl/switch_drop_stats_pkg.sv
// -----------------------------------------------------------------------------
// stats_pkg
// Shared definitions for the switch drop-statistics block:
//   - rd_sel_e    : read-port counter select encoding
//   - DEF_CNT_W / DEF_TOT_W : default counter widths
//   - popcount()  : population count of a target mask (up to POP_MAX_W bits)
// -----------------------------------------------------------------------------
package stats_pkg;

  typedef enum logic [1:0] {
    SEL_ACC      = 2'd0,
    SEL_DROP_PKT = 2'd1,
    SEL_DROP_TGT = 2'd2,
    SEL_TOTAL    = 2'd3
  } rd_sel_e;

  localparam int DEF_CNT_W = 16;
  localparam int DEF_TOT_W = 20;

  // popcount operates on a fixed-width vector; callers zero-extend their mask
  localparam int POP_MAX_W = 32;
  localparam int POP_OUT_W = 6;

  function automatic logic [POP_OUT_W-1:0] popcount(input logic [POP_MAX_W-1:0] v);
    logic [POP_OUT_W-1:0] c;
    c = '0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      c = c + {{(POP_OUT_W-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/switch_drop_stats_sat_counter.sv
// -----------------------------------------------------------------------------
// stats_sat_counter
// Saturating up-counter. Adds i_inc each enabled cycle, clamping at all-ones.
// Ports:
//   i_clk, i_rst_n      : clock, asynchronous active-low reset
//   i_inc [INC_W]       : increment amount for this cycle
//   i_en                : counting enable (increment applied only when high)
//   i_clr               : synchronous clear; wins over everything else
//   i_clr_on_read       : counter is being read destructively this cycle; the
//                         stored value is discarded but this cycle's increment
//                         is kept
//   o_value [W]         : current count
//   o_at_max            : count is all-ones
// -----------------------------------------------------------------------------
module stats_sat_counter #(
  parameter int W     = 16,
  parameter int INC_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [INC_W-1:0] i_inc,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_clr_on_read,
  output logic [W-1:0]     o_value,
  output logic             o_at_max
);

  // One extra bit over the wider operand so the sum can never wrap
  localparam int SW = ((W > INC_W) ? W : INC_W) + 1;
  localparam logic [SW-1:0] MAX_EXT = {{(SW-W){1'b0}}, {W{1'b1}}};

  logic [W-1:0]  r_value;
  logic [W-1:0]  w_base;
  logic [SW-1:0] w_sum;
  logic [W-1:0]  w_next;

  always_comb begin
    w_base = i_clr_on_read ? '0 : r_value;
    w_sum  = SW'(w_base) + SW'(i_inc);
    w_next = w_base;
    if (i_en) begin
      w_next = (w_sum > MAX_EXT) ? {W{1'b1}} : w_sum[W-1:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_value <= '0;
    end else if (i_clr) begin
      r_value <= '0;
    end else begin
      r_value <= w_next;
    end
  end

  assign o_value  = r_value;
  assign o_at_max = &r_value;

endmodule

// File: rtl/switch_drop_stats.sv
// -----------------------------------------------------------------------------
// switch_drop_stats
// Per-port accept/drop statistics for an N-port switch. Each cycle, a port with
// i_valid_in set is an accept if its FIFO is not full, otherwise a drop. Drops
// are also weighted by popcount of the port's target mask (lost output copies),
// both per port and in one aggregate total. All counters saturate.
//
// Ports:
//   i_clk, i_rst_n        : clock, asynchronous active-low reset
//   i_valid_in [NP]       : per-port ingress valid
//   i_target_in [NP*NP]   : per-port target mask, port p at [p*NP +: NP]
//   i_fifo_full [NP]      : per-port ingress FIFO full
//   i_stats_en            : counting enable (low freezes counters)
//   i_clr                 : synchronous clear of all counters and o_sat
//   i_rd_en, i_rd_port, i_rd_sel : read request (sel: acc/drop_pkt/drop_tgt/total)
//   o_rd_valid, o_rd_data : read response, one cycle after the request
//   o_sat [NP]            : sticky "a counter of port p saturated"
//
// Build option: STATS_CLR_ON_READ_EN makes reads destructive (the counter read
// is zeroed on the sampling edge; o_sat[p] clears once all three of port p's
// counters have been read since it was set).
// -----------------------------------------------------------------------------
module switch_drop_stats
  import stats_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int TOT_W     = DEF_TOT_W,
  localparam int PW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [NUM_PORTS-1:0]           i_valid_in,
  input  logic [NUM_PORTS*NUM_PORTS-1:0] i_target_in,
  input  logic [NUM_PORTS-1:0]           i_fifo_full,
  input  logic                           i_stats_en,
  input  logic                           i_clr,
  input  logic                           i_rd_en,
  input  logic [PW-1:0]                  i_rd_port,
  input  logic [1:0]                     i_rd_sel,
  output logic                           o_rd_valid,
  output logic [TOT_W-1:0]               o_rd_data,
  output logic [NUM_PORTS-1:0]           o_sat
);

  localparam int PC_W = $clog2(NUM_PORTS + 1);
  localparam int TI_W = $clog2(NUM_PORTS * NUM_PORTS + 1);
  localparam logic [PW:0] NP_EXT = (PW + 1)'(NUM_PORTS);

  logic [NUM_PORTS-1:0] w_acc_ev;
  logic [NUM_PORTS-1:0] w_drop_ev;
  logic [PC_W-1:0]      w_pc       [NUM_PORTS];
  logic [CNT_W-1:0]     w_acc      [NUM_PORTS];
  logic [CNT_W-1:0]     w_dpkt     [NUM_PORTS];
  logic [CNT_W-1:0]     w_dtgt     [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_acc_max;
  logic [NUM_PORTS-1:0] w_dpkt_max;
  logic [NUM_PORTS-1:0] w_dtgt_max;
  logic [NUM_PORTS-1:0] w_cor_acc;
  logic [NUM_PORTS-1:0] w_cor_dpkt;
  logic [NUM_PORTS-1:0] w_cor_dtgt;
  logic                 w_cor_tot;
  logic [TI_W-1:0]      w_tot_inc;
  logic [TOT_W-1:0]     w_tot;
  logic                 w_tot_max;
  logic                 w_port_ok;
  logic [TOT_W-1:0]     w_rd_data;
  logic [NUM_PORTS-1:0] w_sat_next;

  logic                 r_rd_valid;
  logic [TOT_W-1:0]     r_rd_data;
  logic [NUM_PORTS-1:0] r_sat;

  // ---------------------------------------------------------------- per port
  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign w_acc_ev[gi]  = i_valid_in[gi] & ~i_fifo_full[gi];
      assign w_drop_ev[gi] = i_valid_in[gi] &  i_fifo_full[gi];
      assign w_pc[gi]      = w_drop_ev[gi]
                             ? PC_W'(popcount(POP_MAX_W'(i_target_in[gi*NUM_PORTS +: NUM_PORTS])))
                             : '0;

`ifdef STATS_CLR_ON_READ_EN
      assign w_cor_acc[gi]  = i_rd_en && (i_rd_sel == SEL_ACC)      && (i_rd_port == PW'(gi));
      assign w_cor_dpkt[gi] = i_rd_en && (i_rd_sel == SEL_DROP_PKT) && (i_rd_port == PW'(gi));
      assign w_cor_dtgt[gi] = i_rd_en && (i_rd_sel == SEL_DROP_TGT) && (i_rd_port == PW'(gi));
`else
      assign w_cor_acc[gi]  = 1'b0;
      assign w_cor_dpkt[gi] = 1'b0;
      assign w_cor_dtgt[gi] = 1'b0;
`endif

      stats_sat_counter #(.W(CNT_W), .INC_W(1)) u_acc (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_inc(w_acc_ev[gi]), .i_en(i_stats_en),
        .i_clr(i_clr), .i_clr_on_read(w_cor_acc[gi]),
        .o_value(w_acc[gi]), .o_at_max(w_acc_max[gi])
      );

      stats_sat_counter #(.W(CNT_W), .INC_W(1)) u_dpkt (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_inc(w_drop_ev[gi]), .i_en(i_stats_en),
        .i_clr(i_clr), .i_clr_on_read(w_cor_dpkt[gi]),
        .o_value(w_dpkt[gi]), .o_at_max(w_dpkt_max[gi])
      );

      stats_sat_counter #(.W(CNT_W), .INC_W(PC_W)) u_dtgt (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_inc(w_pc[gi]), .i_en(i_stats_en),
        .i_clr(i_clr), .i_clr_on_read(w_cor_dtgt[gi]),
        .o_value(w_dtgt[gi]), .o_at_max(w_dtgt_max[gi])
      );
    end
  endgenerate

  // ---------------------------------------------------------------- total
  always_comb begin
    w_tot_inc = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_tot_inc = w_tot_inc + TI_W'(w_pc[p]);
    end
  end

`ifdef STATS_CLR_ON_READ_EN
  assign w_cor_tot = i_rd_en && (i_rd_sel == SEL_TOTAL);
`else
  assign w_cor_tot = 1'b0;
`endif

  // Total saturation is reported nowhere; its at_max is intentionally unused.
  stats_sat_counter #(.W(TOT_W), .INC_W(TI_W)) u_total (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_inc(w_tot_inc), .i_en(i_stats_en),
    .i_clr(i_clr), .i_clr_on_read(w_cor_tot),
    .o_value(w_tot), .o_at_max(w_tot_max)
  );

  // ---------------------------------------------------------------- read mux
  // Counter outputs are the registered values, i.e. before this cycle's
  // increment and before any same-cycle clear.
  assign w_port_ok = ({1'b0, i_rd_port} < NP_EXT);

  always_comb begin
    w_rd_data = '0;
    case (rd_sel_e'(i_rd_sel))
      SEL_TOTAL:    w_rd_data = w_tot;
      SEL_ACC:      if (w_port_ok) w_rd_data = TOT_W'(w_acc[i_rd_port]);
      SEL_DROP_PKT: if (w_port_ok) w_rd_data = TOT_W'(w_dpkt[i_rd_port]);
      SEL_DROP_TGT: if (w_port_ok) w_rd_data = TOT_W'(w_dtgt[i_rd_port]);
      default:      w_rd_data = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= i_rd_en;
      if (i_rd_en) begin
        r_rd_data <= w_rd_data;
      end
    end
  end

  // ---------------------------------------------------------------- sat flags
`ifdef STATS_CLR_ON_READ_EN
  // r_seen[p] records which of {dtgt, dpkt, acc} were read since sat[p] rose
  logic [2:0] r_seen      [NUM_PORTS];
  logic [2:0] w_seen_next [NUM_PORTS];

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      logic       any_max;
      logic [2:0] hits;
      logic [2:0] seen_all;
      any_max  = w_acc_max[p] | w_dpkt_max[p] | w_dtgt_max[p];
      hits     = {w_cor_dtgt[p], w_cor_dpkt[p], w_cor_acc[p]};
      seen_all = r_seen[p] | hits;
      w_sat_next[p]  = r_sat[p];
      w_seen_next[p] = r_seen[p];
      if (!r_sat[p]) begin
        w_sat_next[p]  = any_max;
        w_seen_next[p] = any_max ? hits : 3'b000;
      end else if (&seen_all) begin
        w_sat_next[p]  = 1'b0;
        w_seen_next[p] = 3'b000;
      end else begin
        w_seen_next[p] = seen_all;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int p = 0; p < NUM_PORTS; p++) r_seen[p] <= 3'b000;
    end else if (i_clr) begin
      for (int p = 0; p < NUM_PORTS; p++) r_seen[p] <= 3'b000;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) r_seen[p] <= w_seen_next[p];
    end
  end
`else
  assign w_sat_next = r_sat | w_acc_max | w_dpkt_max | w_dtgt_max;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sat <= '0;
    end else if (i_clr) begin
      r_sat <= '0;
    end else begin
      r_sat <= w_sat_next;
    end
  end

  assign o_rd_valid = r_rd_valid;
  assign o_rd_data  = r_rd_data;
  assign o_sat      = r_sat;

endmodule

// File: tb/tb_switch_drop_stats.sv
// Scoreboard bench for switch_drop_stats (NUM_PORTS=4, CNT_W=4, TOT_W=20).
module tb_switch_drop_stats;
  import stats_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  valid, full;
  logic [15:0] target;
  logic        stats_en, clr, rd_en;
  logic [1:0]  rd_port, rd_sel;
  logic        rd_valid;
  logic [19:0] rd_data;
  logic [3:0]  sat;

  int n_cmp = 0;
  int n_bad = 0;

  logic [19:0] exp_q[$];
  string       name_q[$];

  switch_drop_stats #(.NUM_PORTS(4), .CNT_W(4), .TOT_W(20)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid_in(valid), .i_target_in(target),
    .i_fifo_full(full), .i_stats_en(stats_en), .i_clr(clr), .i_rd_en(rd_en),
    .i_rd_port(rd_port), .i_rd_sel(rd_sel), .o_rd_valid(rd_valid),
    .o_rd_data(rd_data), .o_sat(sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end else begin
      $display("ok   %s: %0d", nm, act);
    end
  endtask

  // Monitor: every rd_valid pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_rd_valid: got rd_data %0d, expected no response", rd_data);
      end else begin
        logic [19:0] e;
        string       nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check(nm, 32'(rd_data), 32'(e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int p, input int s, input int exp, input string nm);
    rd_en   = 1'b1;
    rd_port = 2'(p);
    rd_sel  = 2'(s);
    exp_q.push_back(20'(exp));
    name_q.push_back(nm);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic beat(input logic [3:0] v, input logic [3:0] f, input logic [15:0] t);
    valid  = v;
    full   = f;
    target = t;
    tick();
    valid  = '0;
    full   = '0;
    target = '0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; valid = '0; full = '0; target = '0;
    stats_en = 1'b1; clr = 1'b0; rd_en = 1'b0; rd_port = '0; rd_sel = '0;
    #12;
    check("reset_rd_valid", 32'(rd_valid), 0);
    check("reset_rd_data",  32'(rd_data),  0);
    check("reset_sat",      32'(sat),      0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: ten accepts on port 0
    for (int i = 0; i < 10; i++) beat(4'b0001, 4'b0000, 16'h0000);
    rd(0, SEL_ACC,      10, "t1_acc0");
    rd(0, SEL_DROP_PKT,  0, "t1_dpkt0");
    rd(0, SEL_DROP_TGT,  0, "t1_dtgt0");
    do_clr();

    // 2: three drops on port 2, mask 1011
    for (int i = 0; i < 3; i++) beat(4'b0100, 4'b0100, 16'h0B00);
    rd(2, SEL_DROP_PKT, 3, "t2_dpkt2");
    rd(2, SEL_DROP_TGT, 9, "t2_dtgt2");
    rd(0, SEL_TOTAL,    9, "t2_total");
    check("t2_sat", 32'(sat), 0);
    do_clr();

    // 3: all ports drop at once, all-ones masks
    beat(4'b1111, 4'b1111, 16'hFFFF);
    rd(0, SEL_TOTAL, 16, "t3_total");
    for (int p = 0; p < 4; p++) rd(p, SEL_DROP_TGT, 4, $sformatf("t3_dtgt%0d", p));
    do_clr();

    // 4: saturation on port 1 (CNT_W = 4)
    for (int i = 0; i < 20; i++) beat(4'b0010, 4'b0010, 16'h0010);
    check("t4_sat_set", 32'(sat), 32'h2);
    rd(1, SEL_DROP_PKT, 15, "t4_dpkt1");
    rd(1, SEL_DROP_TGT, 15, "t4_dtgt1");
    rd(0, SEL_TOTAL,    20, "t4_total");
    check("t4_sat_hold", 32'(sat), 32'h2);
    do_clr();
    check("t4_sat_clr", 32'(sat), 0);
    rd(1, SEL_DROP_TGT, 0, "t4_dtgt1_clr");

    // 5: read concurrent with an accept, then back-to-back read
    for (int i = 0; i < 5; i++) beat(4'b1000, 4'b0000, 16'h0000);
    valid = 4'b1000; rd_en = 1'b1; rd_port = 2'd3; rd_sel = SEL_ACC;
    exp_q.push_back(20'd5); name_q.push_back("t5_acc3_first");
    tick();
    valid = '0;
`ifdef STATS_CLR_ON_READ_EN
    exp_q.push_back(20'd1);
`else
    exp_q.push_back(20'd6);
`endif
    name_q.push_back("t5_acc3_second");
    tick();
    rd_en = 1'b0;
    do_clr();

    // 6: clear beats a same-cycle drop; stats_en freeze; zero-target drop
    clr = 1'b1;
    beat(4'b0001, 4'b0001, 16'h0003);
    clr = 1'b0;
    rd(0, SEL_DROP_PKT, 0, "t6_dpkt0_clr");
    rd(0, SEL_DROP_TGT, 0, "t6_dtgt0_clr");
    rd(0, SEL_TOTAL,    0, "t6_total_clr");
    stats_en = 1'b0;
    for (int i = 0; i < 5; i++) beat(4'b0001, 4'b0001, 16'h0003);
    stats_en = 1'b1;
    rd(0, SEL_DROP_PKT, 0, "t6_dpkt0_frozen");
    beat(4'b0001, 4'b0001, 16'h0000);
    rd(0, SEL_DROP_PKT, 1, "t6_dpkt0_zero_tgt");
    rd(0, SEL_DROP_TGT, 0, "t6_dtgt0_zero_tgt");

    // reset while a read is pending
    for (int i = 0; i < 16; i++) beat(4'b0100, 4'b0100, 16'h0100);
    check("t6_sat2_set", 32'(sat), 32'h4);
    rd_en = 1'b1; rd_port = 2'd2; rd_sel = SEL_DROP_PKT;
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_rst_rd_valid", 32'(rd_valid), 0);
    check("t6_rst_rd_data",  32'(rd_data),  0);
    check("t6_rst_sat",      32'(sat),      0);
    rd_en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    rd(2, SEL_DROP_PKT, 0, "t6_dpkt2_after_rst");

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d outstanding reads, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
